// File: rtl/bcd_7seg_scan_driver_if.sv
// Display-driver bundle: load-side digit data in, multiplexed pin-level segment/anode drive out.
// The master drives en/load/bcd_in/dp_in; the slave (scan driver) drives the pins and frame_done.
interface bcd_7seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output en, load, bcd_in, dp_in,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  en, load, bcd_in, dp_in,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed BCD-to-7-segment scan driver with tear-free double buffering; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: pins are registered one cycle after the divider/digit position; loads appear from the next frame.
// Backpressure: none; load is always accepted (last write before a frame boundary wins), en=0 freezes the scan.
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 4,
    parameter int COMMON_ANODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_7seg_scan_driver_if.slave  bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic POL = (COMMON_ANODE != 0);

    logic [CNT_W-1:0]            div_cnt;
    logic [IDX_W-1:0]            idx;
    logic [NUM_DIGITS-1:0][3:0]  pend_bcd;
    logic [NUM_DIGITS-1:0]       pend_dp;
    logic                        pend_vld;
    logic [NUM_DIGITS-1:0][3:0]  act_bcd;
    logic [NUM_DIGITS-1:0]       act_dp;
    logic [6:0]                  seg_q;
    logic                        dp_q;
    logic [NUM_DIGITS-1:0]       an_q;
    logic                        frame_done_q;

    logic                        slot_end;
    logic                        frame_end;
    logic                        in_guard;
    logic [6:0]                  cur_seg;
    logic [NUM_DIGITS-1:0]       an_sel;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000001;
        endcase
    endfunction

    assign slot_end  = bus.en && (div_cnt == LAST_CNT);
    assign frame_end = slot_end && (idx == LAST_IDX);
    assign in_guard  = (32'(div_cnt) < 32'(GUARD));
    assign an_sel    = NUM_DIGITS'(1) << idx;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;

    // A digit blanks only while it and everything above it is zero; digit 0 never blanks.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (act_bcd[k] == 4'd0);
            blank[k]   = upper_zero && (k != 0);
        end
    end

    assign cur_seg = blank[idx] ? 7'b0 : decode(act_bcd[idx]);
`else
    assign cur_seg = decode(act_bcd[idx]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (bus.en) begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // The frame-boundary copy takes the pre-edge pending value, so a load on that cycle stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bcd <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            act_bcd  <= '0;
            act_dp   <= '0;
        end else begin
            if (frame_end && pend_vld) begin
                act_bcd <= pend_bcd;
                act_dp  <= pend_dp;
            end
            if (bus.load) begin
                pend_bcd <= bus.bcd_in;
                pend_dp  <= bus.dp_in;
                pend_vld <= 1'b1;
            end else if (frame_end) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= {7{POL}};
            dp_q         <= POL;
            an_q         <= {NUM_DIGITS{POL}};
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (bus.en) begin
                seg_q <= cur_seg ^ {7{POL}};
                dp_q  <= act_dp[idx] ^ POL;
                an_q  <= (in_guard ? '0 : an_sel) ^ {NUM_DIGITS{POL}};
            end else begin
                seg_q <= {7{POL}};
                dp_q  <= POL;
                an_q  <= {NUM_DIGITS{POL}};
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench: a timeline model pushes expected pin states per clock, popped and compared after each edge.
// Two instances share stimulus: active-high pins and common-anode (inverted) pins.
module tb_bcd_7seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GD = 2;
    localparam int FRAME = RD * ND;

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] an;
        logic          fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();
    bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();

    assign bus1.en     = bus0.en;
    assign bus1.load   = bus0.load;
    assign bus1.bcd_in = bus0.bcd_in;
    assign bus1.dp_in  = bus0.dp_in;

    bcd_7seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD), .COMMON_ANODE(0)) dut_ch (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    bcd_7seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD), .COMMON_ANODE(1)) dut_ca (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "init";
    exp_t  sb_q[$];

    int          m_t;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    bit          m_pv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    function automatic string seg_letters(input int v);
        case (v)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "g";
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int k);
        string s;
        logic [6:0] r;
        int v;
        r = '0;
        v = int'((m_act >> (4 * k)) & 16'hF);
        s = seg_letters(v);
        for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (k != 0 && (m_act >> (4 * k)) == 16'h0) r = '0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_pv = 0;
        sb_q.delete();
    endtask

    task automatic tick();
        exp_t e;
        int d, k;
        bit bnd;
        logic [6:0] nseg;
        logic       ndp;
        logic [ND-1:0] nan;
        e   = '0;
        d   = m_t % RD;
        k   = (m_t / RD) % ND;
        bnd = bus0.en && ((m_t % FRAME) == FRAME - 1);
        if (bus0.en) begin
            e.an  = (d >= GD) ? ND'(1 << k) : '0;
            e.seg = exp_seg(k);
            e.dp  = m_adp[k];
        end
        e.fd = bnd;
        sb_q.push_back(e);
        if (bnd && m_pv) begin m_act = m_pend; m_adp = m_pdp; m_pv = 0; end
        if (bus0.load) begin m_pend = bus0.bcd_in; m_pdp = bus0.dp_in; m_pv = 1; end
        if (bus0.en) m_t++;

        @(posedge clk);
        #1;
        e    = sb_q.pop_front();
        nseg = ~e.seg;
        ndp  = ~e.dp;
        nan  = ~e.an;
        chk("seg",    bus0.seg,        e.seg);
        chk("dp",     bus0.dp,         e.dp);
        chk("an",     bus0.an,         e.an);
        chk("fd",     bus0.frame_done, e.fd);
        chk("ca_seg", bus1.seg,        nseg);
        chk("ca_dp",  bus1.dp,         ndp);
        chk("ca_an",  bus1.an,         nan);
        chk("ca_fd",  bus1.frame_done, e.fd);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        bus0.load = 1'b1; bus0.bcd_in = v; bus0.dp_in = p;
        tick();
        bus0.load = 1'b0;
    endtask

    task automatic run_to(input int frame_pos);
        for (int i = 0; i < FRAME && (m_t % FRAME) != frame_pos; i++) tick();
    endtask

    task automatic chk_reset_pins();
        chk("rst_seg",    bus0.seg, 7'h00);
        chk("rst_dp",     bus0.dp, 1'b0);
        chk("rst_an",     bus0.an, 4'h0);
        chk("rst_fd",     bus0.frame_done, 1'b0);
        chk("rst_ca_seg", bus1.seg, 7'h7F);
        chk("rst_ca_dp",  bus1.dp, 1'b1);
        chk("rst_ca_an",  bus1.an, 4'hF);
        chk("rst_ca_fd",  bus1.frame_done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.en = 1'b0; bus0.load = 1'b0; bus0.bcd_in = '0; bus0.dp_in = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        phase = "reset";
        chk_reset_pins();
        rst_n = 1'b1;

        phase = "zeros";
        bus0.en = 1'b1;
        repeat (40) tick();

        phase = "load1234";
        run_to(10);
        do_load(16'h1234, 4'b0100);
        repeat (70) tick();

        phase = "invalid";
        do_load(16'h00AF, 4'b0000);
        repeat (70) tick();

        phase = "lzb";
        do_load(16'h0050, 4'b0010);
        repeat (70) tick();

        phase = "overwrite";
        run_to(5);
        do_load(16'h1111, 4'b0000);
        repeat (6) tick();
        do_load(16'h9999, 4'b1111);
        repeat (70) tick();

        phase = "boundary";
        run_to(12);
        do_load(16'h4321, 4'b0001);
        run_to(FRAME - 1);
        do_load(16'h8765, 4'b1000);
        repeat (70) tick();

        phase = "disable";
        run_to(RD + 4);
        bus0.en = 1'b0;
        repeat (3) tick();
        do_load(16'h5678, 4'b0011);
        repeat (16) tick();
        bus0.en = 1'b1;
        repeat (80) tick();

        phase = "async_rst";
        do_load(16'h4444, 4'b1111);
        run_to(2 * RD + 3);
        #2 rst_n = 1'b0;
        #1 chk_reset_pins();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        phase = "post_rst";
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
